// File: rtl/dct_col_stage_pkg.sv
// Shared constants for the 8-point column DCT: coefficient magnitudes,
// per-row sign table and default widths.
package dct_col_stage_pkg;

    localparam int SIZE_DEF        = 8;
    localparam int APPROX_BITS_DEF = 0;

    typedef logic [6:0] coef_t;

    localparam coef_t CA = 7'd64;
    localparam coef_t CB = 7'd60;
    localparam coef_t CC = 7'd56;
    localparam coef_t CD = 7'd45;
    localparam coef_t CE = 7'd36;
    localparam coef_t CF = 7'd24;
    localparam coef_t CG = 7'd12;

    // Magnitude of the coefficient applied to x[j] in row r.
    localparam coef_t ROW_MAG [0:7][0:7] = '{
        '{CD, CD, CD, CD, CD, CD, CD, CD},
        '{CA, CC, CE, CG, CG, CE, CC, CA},
        '{CB, CF, CF, CB, CB, CF, CF, CB},
        '{CC, CG, CA, CE, CE, CA, CG, CC},
        '{CD, CD, CD, CD, CD, CD, CD, CD},
        '{CE, CA, CG, CC, CC, CG, CA, CE},
        '{CF, CB, CB, CF, CF, CB, CB, CF},
        '{CG, CE, CC, CA, CA, CC, CE, CG}
    };

    // Bit j set means the x[j] term of that row is subtracted.
    localparam logic [0:7] ROW_NEG [0:7] = '{
        8'b0000_0000,
        8'b0000_1111,
        8'b0011_1100,
        8'b0111_0001,
        8'b0110_0110,
        8'b0100_1101,
        8'b0101_1010,
        8'b0101_0101
    };

    function automatic int neg_count(input logic [0:7] neg);
        return $countones(neg);
    endfunction

endpackage

// File: rtl/dct_col_stage_csa_eight.sv
// Eight operands plus a constant reduced by a 3:2 carry-save tree,
// finished with a single carry-propagate add. Arithmetic is modulo 2^W.
module csa_eight #(
    parameter int W = 19
) (
    input  logic [W-1:0] i_op [0:7],
    input  logic [W-1:0] i_const,
    output logic [W-1:0] o_sum
);

    function automatic logic [2*W-1:0] csa(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c);
        logic [W-1:0] carry;
        carry = ((a & b) | (a & c) | (b & c)) << 1;
        return {a ^ b ^ c, carry};
    endfunction

    logic [W-1:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2;
    logic [W-1:0] w_s3, w_c3, w_s4, w_c4;
    logic [W-1:0] w_s5, w_c5, w_s6, w_c6;

    // 9 -> 6 -> 4 -> 3 -> 2 operands, then one CPA.
    assign {w_s0, w_c0} = csa(i_op[0], i_op[1], i_op[2]);
    assign {w_s1, w_c1} = csa(i_op[3], i_op[4], i_op[5]);
    assign {w_s2, w_c2} = csa(i_op[6], i_op[7], i_const);
    assign {w_s3, w_c3} = csa(w_s0, w_c0, w_s1);
    assign {w_s4, w_c4} = csa(w_c1, w_s2, w_c2);
    assign {w_s5, w_c5} = csa(w_s3, w_c3, w_s4);
    assign {w_s6, w_c6} = csa(w_s5, w_c5, w_c4);

    assign o_sum = w_s6 + w_c6;

endmodule

// File: rtl/dct_col_stage.sv
// Column-pass 8-point DCT stage: all eight row sums are formed every cycle,
// and the row selected by the free-running counter is captured on wr_en.
module dct_col_stage
    import dct_col_stage_pkg::*;
#(
    parameter int SIZE        = SIZE_DEF,
    parameter int APPROX_BITS = APPROX_BITS_DEF,
    parameter int SIZE_MULT   = SIZE + 6,
    parameter int SIZE_OUT    = SIZE + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       wr_en,
    input  logic signed [SIZE-1:0]     data_in  [0:7],
    input  logic                       approx_en,
    output logic signed [SIZE_OUT-1:0] data_out [0:7],
    output logic                       done
);

    localparam int SUM_W = SIZE_MULT + 5;

    logic [2:0]                 r_cnt;
    logic signed [SIZE_OUT-1:0] r_data_out [0:7];
    logic [SUM_W-1:0]           w_sum      [0:7];
    logic signed [SIZE_OUT-1:0] w_y        [0:7];
    logic [SIZE_MULT-1:0]       w_mask;

    assign w_mask = approx_en ? ({SIZE_MULT{1'b1}} << APPROX_BITS) : {SIZE_MULT{1'b1}};

    for (genvar r = 0; r < 8; r++) begin : g_row
        localparam logic [SUM_W-1:0] ROW_CONST = SUM_W'(neg_count(ROW_NEG[r]));

        logic [SUM_W-1:0] w_term [0:7];
        logic             w_unused_bits;

        for (genvar j = 0; j < 8; j++) begin : g_col
            logic signed [SIZE_MULT-1:0] w_prod;

            assign w_prod = (SIZE_MULT'(data_in[j])
                             * $signed({{(SIZE_MULT-7){1'b0}}, ROW_MAG[r][j]})) & w_mask;
            // Subtraction as ~p; the +1 per negated term lives in ROW_CONST.
            assign w_term[j] = ROW_NEG[r][j] ? ~SUM_W'(w_prod) : SUM_W'(w_prod);
        end

        csa_eight #(.W(SUM_W)) u_csa (
            .i_op    (w_term),
            .i_const (ROW_CONST),
            .o_sum   (w_sum[r])
        );

        assign w_y[r]        = w_sum[r][SIZE_OUT+6:7];
        assign w_unused_bits = ^{w_sum[r][SUM_W-1:SIZE_OUT+7], w_sum[r][6:0]};
    end

    // NOTE: the output registers are architectural state and must read zero
    // straight out of reset, so they sit inside the async reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                r_data_out[i] <= '0;
            end
        end else if (wr_en) begin
            r_data_out[r_cnt] <= w_y[r_cnt];
            r_cnt             <= (start || r_cnt == 3'd7) ? 3'd0 : 3'(r_cnt + 3'd1);
        end
    end

    assign data_out = r_data_out;
    assign done     = (r_cnt == 3'd7);

endmodule

// File: tb/tb_dct_col_stage.sv
// Self-checking bench for dct_col_stage: spec vectors from a table, directed
// reset/restart/hold sequences and random traffic against an integer model.
module tb_dct_col_stage;

    localparam int SIZE        = 8;
    localparam int APPROX_BITS = 0;
    localparam int SIZE_OUT    = SIZE + 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic                       wr_en;
    logic                       approx_en;
    logic signed [SIZE-1:0]     data_in  [0:7];
    logic signed [SIZE_OUT-1:0] data_out [0:7];
    logic                       done;

    dct_col_stage #(.SIZE(SIZE), .APPROX_BITS(APPROX_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .approx_en (approx_en),
        .data_out  (data_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Signed DCT matrix written out directly from the coefficient rules.
    int coef [8][8] = '{
        '{45,  45,  45,  45,  45,  45,  45,  45},
        '{64,  56,  36,  12, -12, -36, -56, -64},
        '{60,  24, -24, -60, -60, -24,  24,  60},
        '{56, -12, -64, -36,  36,  64,  12, -56},
        '{45, -45, -45,  45,  45, -45, -45,  45},
        '{36, -64,  12,  56, -56, -12,  64, -36},
        '{24, -60,  60, -24, -24,  60, -60,  24},
        '{12, -36,  56, -64,  64, -56,  36, -12}
    };

    int m_cnt;
    int m_out [8];

    typedef struct {
        int x   [8];
        int exp [8];
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_y(input int row, input bit approx);
        int sum = 0;
        int p;
        for (int j = 0; j < 8; j++) begin
            p = (coef[row][j] < 0 ? -coef[row][j] : coef[row][j]) * int'(data_in[j]);
            if (approx && APPROX_BITS > 0) p = p & ~((1 << APPROX_BITS) - 1);
            sum += (coef[row][j] < 0) ? -p : p;
        end
        sum = sum >>> 7;
        return ((sum + (1 << (SIZE_OUT - 1))) & ((1 << SIZE_OUT) - 1)) - (1 << (SIZE_OUT - 1));
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s out[%0d]", tag, i), data_out[i], m_out[i]);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 8; i++) m_out[i] = 0;
    endtask

    task automatic set_x(input int v [8]);
        for (int j = 0; j < 8; j++) data_in[j] = SIZE'(v[j]);
    endtask

    task automatic rand_x();
        for (int j = 0; j < 8; j++) data_in[j] = SIZE'($urandom_range(0, 255));
    endtask

    // One clock: drive controls, check done before the edge, update the
    // model at the edge and compare all outputs just after it.
    task automatic do_cycle(input string tag, input bit we, input bit st, input bit ap);
        int y;
        start     = st;
        wr_en     = we;
        approx_en = ap;
        check({tag, " done"}, done, (m_cnt == 7));
        y = ref_y(m_cnt, ap);
        @(posedge clk);
        if (we) begin
            m_out[m_cnt] = y;
            m_cnt = (st || m_cnt == 7) ? 0 : m_cnt + 1;
        end
        #1;
        wr_en = 1'b0;
        start = 1'b0;
        check_all(tag);
    endtask

    initial begin
        tbl[0].x   = '{64, 64, 64, 64, 64, 64, 64, 64};
        tbl[0].exp = '{180, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].x   = '{127, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].exp = '{44, 63, 59, 55, 44, 35, 23, 11};
        tbl[2].x   = '{-128, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].exp = '{-45, -64, -60, -56, -45, -36, -24, -12};

        rst_n     = 1'b0;
        start     = 1'b0;
        wr_en     = 1'b0;
        approx_en = 1'b0;
        for (int j = 0; j < 8; j++) data_in[j] = '0;
        model_reset();
        #12;
        check("reset done", done, 1'b0);
        check_all("reset");
        rst_n = 1'b1;

        foreach (tbl[v]) begin
            set_x(tbl[v].x);
            for (int k = 0; k < 8; k++) do_cycle($sformatf("vec%0d cyc%0d", v, k), 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++)
                check($sformatf("vec%0d table out[%0d]", v, i), data_out[i], tbl[v].exp[i]);
        end

        // Reset in the middle of a sequence.
        for (int k = 0; k < 3; k++) begin
            rand_x();
            do_cycle("pre-reset", 1'b1, 1'b0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset done", done, 1'b0);
        check_all("midreset");
        #2 rst_n = 1'b1;
        rand_x();
        do_cycle("post-reset row0", 1'b1, 1'b0, 1'b0);

        // Restart from row 3: capture row 3, then row 0 is next.
        for (int k = 0; k < 2; k++) begin
            rand_x();
            do_cycle("pre-start", 1'b1, 1'b0, 1'b0);
        end
        rand_x();
        do_cycle("start row3", 1'b1, 1'b1, 1'b0);
        check("start cnt cleared", m_cnt, 0);
        rand_x();
        do_cycle("after start row0", 1'b1, 1'b0, 1'b0);

        // Hold: no wr_en while inputs and start wiggle.
        for (int k = 0; k < 5; k++) begin
            rand_x();
            do_cycle("hold", 1'b0, k[0], 1'b1);
        end
        rand_x();
        do_cycle("after hold", 1'b1, 1'b0, 1'b0);

        // approx_en has no effect with APPROX_BITS = 0.
        rand_x();
        for (int k = 0; k < 8; k++) do_cycle("approx on", 1'b1, 1'b0, 1'b1);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) != 0) rand_x();
            do_cycle("random", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dct_col_stage.md
# dct_col_stage

Single-stage 8-point 1-D DCT (column pass) for the hierarchical JPEG DCT datapath. Each `wr_en` cycle it multiplies the eight signed input samples by one row of a fixed 7-bit integer DCT matrix. It sums the products exactly, scales by 2^-7 and stores the result in output register `cnt`. A free-running 0..7 counter selects the row, so eight `wr_en` cycles produce one full coefficient vector.

## Interface
- `SIZE`, 8, input sample width (signed).
- `APPROX_BITS`, 0, number of LSBs of each product that may be approximated when `approx_en`=1.
- `SIZE_MULT`, SIZE+6, product width (signed).
- `SIZE_OUT`, SIZE+2, output coefficient width (signed).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: restart the row counter (qualified by `wr_en`).
- `wr_en` in 1: advance the counter and capture one coefficient.
- `data_in[0:7]` in 8×SIZE: signed samples x0..x7, held stable while in use.
- `approx_en` in 1: enable approximate LSB arithmetic.
- `data_out[0:7]` out 8×SIZE_OUT: signed registered coefficients y0..y7.
- `done` out 1: combinational, high while `cnt`==7.

## Operation
- Coefficient constants: a=64, b=60, c=56, d=45, e=36, f=24, g=12.
- Row r coefficients for x0..x7:
  - r0: d,d,d,d,d,d,d,d
  - r1: a,c,e,g,−g,−e,−c,−a
  - r2: b,f,−f,−b,−b,−f,f,b
  - r3: c,−g,−a,−e,e,a,g,−c
  - r4: d,−d,−d,d,d,−d,−d,d
  - r5: e,−a,g,c,−c,−g,a,−e
  - r6: f,−b,b,−f,−f,b,−b,f
  - r7: g,−e,c,−a,a,−c,e,−g
- Products are SIZE_MULT-bit signed.
- Negated terms are formed as bitwise inverse. The row adds a constant of 4 (one LSB per negated term) so the negation is exact two's complement. Row 0 adds 0.
- Sum width is SIZE_MULT+5, signed. The exact result is sum_r = Σ coeff·x.
- Scaled value: y_r = sum_r[SIZE_OUT+6:7], i.e. arithmetic shift right 7 (floor) truncated to SIZE_OUT bits. For SIZE=8 no overflow is possible (max |y| = 360).
- Approximation:
  - `approx_en`=1 and APPROX_BITS>0: the low APPROX_BITS of every product are forced to 0 before summation.
  - `approx_en`=0 or APPROX_BITS=0: arithmetic is exact.
- All eight row sums are computed combinationally every cycle. Only row `cnt` is captured.

## Timing
- Reset (async, `rst_n`=0): `cnt`=0, all `data_out`=0, `done`=0.
- On a rising edge with `wr_en`=1:
  - `data_out[cnt]` ← y_cnt computed from the current `data_in`.
  - All other `data_out` entries hold.
  - `cnt` ← 0 if `start`=1 or `cnt`==7, else `cnt`+1.
- `wr_en`=0: all state holds. `start` without `wr_en` has no effect.
- With `start` and `wr_en` both high, the capture still uses the pre-start `cnt`; the next `wr_en` writes `data_out[0]`.
- Latency: `data_out[i]` is valid one edge after the `wr_en` cycle in which `cnt`==i.
- The full vector is valid after the 8th `wr_en` following reset or start. `done` is high during that 8th `wr_en` cycle.
- Reset mid-sequence clears everything immediately; the sequence restarts at row 0.

## Structure
- Shared package: the coefficient constants a..g, the row sign/coefficient table, and default widths.
- Natural sub-module: `csa_eight`, an 8-input plus constant carry-save adder tree with a final CPA, instantiated once per row.
- Multipliers by constant may be inline shift-add. The counter and output registers stay in the top level.

## Test plan
- Reset: assert `rst_n`=0 mid-run → all `data_out`=0 and `done`=0 immediately. After release, the first `wr_en` writes `data_out[0]`.
- DC: all x=64, 8 `wr_en` cycles → `data_out`={180,0,0,0,0,0,0,0}; `done` high only in the 8th cycle.
- Positive impulse: x0=127, others 0, 8 `wr_en` cycles → {44,63,59,55,44,35,23,11}.
- Negative impulse: x0=−128, others 0 → {−45,−64,−60,−56,−45,−36,−24,−12}.
- Restart: 3 `wr_en` cycles, then `start`+`wr_en` → `data_out[3]` captured and `cnt`=0. The next `wr_en` updates `data_out[0]` only.
- Hold: `wr_en`=0 for 5 cycles while `data_in` changes → `cnt` and `data_out` unchanged. `approx_en` toggling with APPROX_BITS=0 → results identical.
